// File: rtl/keypad_encoder_if.sv
// Consumer-side bundle for keypad_encoder: key code FIFO head, valid/ready
// handshake and the sticky overflow flag with its clear.
interface keypad_encoder_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;
    logic       overflow_clr;

    modport master (
        output key_code,
        output key_valid,
        output overflow,
        input  key_ready,
        input  overflow_clr
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overflow,
        output key_ready,
        output overflow_clr
    );
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: 16-button front-end. Synchronizes pb, optionally debounces
// (compile with KEYPAD_DEBOUNCE_EN), detects presses and queues one 4-bit key
// code per press in a DEPTH-entry FIFO popped through a valid/ready handshake.
module keypad_encoder #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [15:0]       pb,
    keypad_encoder_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [15:0]   s1_q, s2_q;
    logic [15:0]   clean;
    logic [15:0]   clean_d_q;
    logic [15:0]   pending_q, pending_d;
    logic [15:0]   rise, cand, push_bit;
    logic [3:0]    push_idx;
    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q, overflow_d;
    logic          valid, pop, push, space, lost;

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pb;
            s2_q <= s1_q;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt_q [16];
    logic [15:0]   clean_q;

    // Per-bit debounce: accept a new level only after it has been stable long enough
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clean_q <= '0;
            for (int i = 0; i < 16; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (s2_q[i] == clean_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_MAX) begin
                    clean_q[i]  <= s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign clean = clean_q;
`else
    assign clean = s2_q;
`endif

    assign rise  = clean & ~clean_d_q;
    assign cand  = pending_q | rise;
    assign valid = (count_q != '0);
    assign pop   = valid & bus.key_ready;
    assign space = (count_q != DEPTH_C) | pop;
    assign push  = (cand != '0) & space;

    // Select the lowest-index candidate, update pending and detect lost presses
    always_comb begin
        push_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cand[i]) push_idx = 4'(i);
        end
        push_bit   = push ? (cand & (~cand + 16'd1)) : 16'd0;
        pending_d  = cand & ~push_bit;
        // A repeat press of a still-pending button merges into it and is lost
        lost       = |(rise & pending_q & ~push_bit);
        overflow_d = overflow_q;
        if (bus.overflow_clr) overflow_d = 1'b0;
        if (lost)             overflow_d = 1'b1;
    end

    // Edge-detect history, pending set, FIFO pointers/count and overflow flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clean_d_q  <= '0;
            pending_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            clean_d_q  <= clean;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_idx;
    end

    assign bus.key_valid = valid;
    assign bus.key_code  = valid ? mem_q[rd_ptr_q] : 4'd0;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed testbench for keypad_encoder (DEPTH=4). Debounce scenarios are
// compiled in only when KEYPAD_DEBOUNCE_EN is defined.
module tb_keypad_encoder;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        n_rst;
    logic [15:0] pb;
    int          tests;
    int          fails;

    keypad_encoder_if kif ();

    keypad_encoder #(
        .DEPTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .pb    (pb),
        .bus   (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        pb[b] = 1'b1;
        repeat (LAT + 2) tick();
        pb[b] = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30 && !kif.key_valid; i++) tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b want 0", kif.key_valid);
        end
        tests++;
        if (kif.key_code !== 4'd0) begin
            fails++; $display("FAIL reset_code got %0d want 0", kif.key_code);
        end
        tests++;
        if (kif.overflow !== 1'b0) begin
            fails++; $display("FAIL reset_overflow got %b want 0", kif.overflow);
        end
        tick();
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        kif.key_ready = 1'b0;
        pb[15] = 1'b1;
        repeat (LAT - 1) tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL single_early got valid %b want 0", kif.key_valid);
        end
        tick();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd15) begin
            fails++;
            $display("FAIL single_latency got valid %b code %0d want 1/15",
                     kif.key_valid, kif.key_code);
        end
        repeat (20 - LAT) tick();
        pb[15] = 1'b0;
        kif.key_ready = 1'b1;
        tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL single_pop got valid %b want 0", kif.key_valid);
        end
        repeat (LAT + 6) tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL single_release got valid %b want 0", kif.key_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp [3];
        exp[0] = 4'd0; exp[1] = 4'd3; exp[2] = 4'd9;
        kif.key_ready = 1'b1;
        pb[0] = 1'b1; pb[3] = 1'b1; pb[9] = 1'b1;
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== exp[i]) begin
                fails++;
                $display("FAIL simul_%0d got valid %b code %0d want 1/%0d",
                         i, kif.key_valid, kif.key_code, exp[i]);
            end
            tick();
        end
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL simul_drain got valid %b want 0", kif.key_valid);
        end
        pb = '0;
        repeat (LAT + 4) tick();
    endtask

    task automatic test_overflow();
        kif.key_ready = 1'b0;
        for (int b = 1; b <= 5; b++) press(b);
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd1 || kif.overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_full got valid %b code %0d ovf %b want 1/1/0",
                     kif.key_valid, kif.key_code, kif.overflow);
        end
        press(5);
        tests++;
        if (kif.overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_set got %b want 1", kif.overflow);
        end
        kif.key_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tests++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== 4'(c)) begin
                fails++;
                $display("FAIL ovf_pop_%0d got valid %b code %0d want 1/%0d",
                         c, kif.key_valid, kif.key_code, c);
            end
            tick();
        end
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL ovf_drain got valid %b want 0", kif.key_valid);
        end
        tests++;
        if (kif.overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got %b want 1", kif.overflow);
        end
        kif.overflow_clr = 1'b1;
        tick();
        kif.overflow_clr = 1'b0;
        tests++;
        if (kif.overflow !== 1'b0) begin
            fails++; $display("FAIL ovf_clear got %b want 0", kif.overflow);
        end
        kif.key_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        kif.key_ready = 1'b0;
        for (int b = 10; b <= 14; b++) press(b);
        kif.key_ready = 1'b1;
        // Pop of 10 coincides with push of pending 14; order must hold at count 4
        for (int c = 10; c <= 14; c++) begin
            tests++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== 4'(c)) begin
                fails++;
                $display("FAIL b2b_%0d got valid %b code %0d want 1/%0d",
                         c, kif.key_valid, kif.key_code, c);
            end
            tick();
        end
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got valid %b want 0", kif.key_valid);
        end
        // Three fill/drain rounds push pointers through several wraps
        for (int r = 0; r < 3; r++) begin
            kif.key_ready = 1'b0;
            for (int k = 0; k < 4; k++) press(r * 4 + k + 2);
            kif.key_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (kif.key_valid !== 1'b1 || kif.key_code !== 4'(r * 4 + k + 2)) begin
                    fails++;
                    $display("FAIL wrap_r%0d_%0d got valid %b code %0d want 1/%0d",
                             r, k, kif.key_valid, kif.key_code, r * 4 + k + 2);
                end
                tick();
            end
        end
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL wrap_drain got valid %b want 0", kif.key_valid);
        end
    endtask

`ifdef KEYPAD_DEBOUNCE_EN
    task automatic test_debounce();
        kif.key_ready = 1'b0;
        pb[7] = 1'b1;
        repeat (2) tick();
        pb[7] = 1'b0;
        repeat (15) tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL db_glitch got valid %b want 0", kif.key_valid);
        end
        pb[7] = 1'b1; tick();
        pb[7] = 1'b0; tick();
        pb[7] = 1'b1; tick();
        pb[7] = 1'b0; tick();
        pb[7] = 1'b1;
        wait_valid();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd7) begin
            fails++;
            $display("FAIL db_bounce got valid %b code %0d want 1/7",
                     kif.key_valid, kif.key_code);
        end
        kif.key_ready = 1'b1;
        repeat (15) tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL db_single got valid %b want 0", kif.key_valid);
        end
        pb[7] = 1'b0;
        repeat (12) tick();
        kif.key_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        kif.key_ready = 1'b0;
        press(4);
        press(6);
        pb[2] = 1'b1;
        repeat (2) tick();
        n_rst = 1'b0;
        #1;
        tests++;
        if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0 || kif.overflow !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got valid %b code %0d ovf %b want 0/0/0",
                     kif.key_valid, kif.key_code, kif.overflow);
        end
        repeat (2) tick();
        n_rst = 1'b1;
        wait_valid();
        tests++;
        if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd2) begin
            fails++;
            $display("FAIL rst_held got valid %b code %0d want 1/2",
                     kif.key_valid, kif.key_code);
        end
        kif.key_ready = 1'b1;
        repeat (12) tick();
        tests++;
        if (kif.key_valid !== 1'b0) begin
            fails++; $display("FAIL rst_once got valid %b want 0", kif.key_valid);
        end
        pb = '0;
        kif.key_ready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pb = '0;
        kif.key_ready = 1'b0;
        kif.overflow_clr = 1'b0;
        n_rst = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
`ifdef KEYPAD_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
